// File: rtl/regfile_sb.sv
// regfile_sb: register file with a per-register pending (scoreboard) bit,
// a power-up clear sequence that zeroes every entry one per clock, and
// optional same-cycle write-to-read forwarding.
module regfile_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREGS    = 32,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ready,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            we,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wd,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_rd
);

    localparam logic ST_INIT = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    logic             state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic [NREGS-1:0] busy_q, busy_d;
    logic [XLEN-1:0]  regs_q [NREGS];

    logic             run;
    logic             wr_ok;
    logic             set_ok;
    logic             rf_we;
    logic [AW-1:0]    rf_waddr;
    logic [XLEN-1:0]  rf_wdata;

    // Register 0 is read-only when it is hardwired to zero.
    function automatic logic writable(input logic [AW-1:0] addr);
        return (ZERO_REG == 0) || (addr != '0);
    endfunction

    assign run    = (state_q == ST_RUN);
    assign wr_ok  = run && we && writable(rd);
    assign set_ok = run && busy_set && writable(busy_rd);
    assign ready  = ready_q;

    // Control state, clear counter, ready flag and scoreboard bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next state: sweep zeros through the array, then serve writes and
    // scoreboard updates; a set lands after the clear so set wins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        rf_we    = 1'b0;
        rf_waddr = rd;
        rf_wdata = wd;
        case (state_q)
            ST_INIT: begin
                rf_we    = 1'b1;
                rf_waddr = cnt_q;
                rf_wdata = '0;
                cnt_d    = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            default: begin
                rf_we = wr_ok;
                if (wr_ok) begin
                    busy_d[rd] = 1'b0;
                end
                if (set_ok) begin
                    busy_d[busy_rd] = 1'b1;
                end
            end
        endcase
    end

    // Storage array; no reset, contents are established by the clear sweep.
    always_ff @(posedge clk) begin
        if (rst_n && rf_we) begin
            regs_q[rf_waddr] <= rf_wdata;
        end
    end

    // Read port 1: zero register, then forwarding, then stored value.
    always_comb begin
        rd1      = '0;
        rs1_busy = 1'b0;
        if (run && writable(rs1)) begin
            if ((BYPASS != 0) && wr_ok && (rd == rs1)) begin
                rd1 = wd;
            end else begin
                rd1      = regs_q[rs1];
                rs1_busy = busy_q[rs1];
            end
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        rd2      = '0;
        rs2_busy = 1'b0;
        if (run && writable(rs2)) begin
            if ((BYPASS != 0) && wr_ok && (rd == rs2)) begin
                rd2 = wd;
            end else begin
                rd2      = regs_q[rs2];
                rs2_busy = busy_q[rs2];
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default instance (A), a no-forwarding instance (B)
// sharing A's stimulus, and a 64-bit/16-entry/no-zero-register instance (C).
module tb_regfile_sb;

    localparam int unsigned XL  = 32;
    localparam int unsigned NR  = 32;
    localparam int unsigned AWA = 5;
    localparam int unsigned XC  = 64;
    localparam int unsigned NRC = 16;
    localparam int unsigned AWC = 4;

    localparam int D_NONE    = 0;
    localparam int D_RSTCNT  = 1;
    localparam int D_ZERO    = 2;
    localparam int D_BYP     = 3;
    localparam int D_BYP2    = 4;
    localparam int D_Z0      = 5;
    localparam int D_SET7    = 6;
    localparam int D_B7      = 7;
    localparam int D_W7      = 8;
    localparam int D_B7CLR   = 9;
    localparam int D_WS7     = 10;
    localparam int D_WS7B    = 11;
    localparam int D_B3      = 12;
    localparam int D_RST     = 13;
    localparam int D_C1      = 14;
    localparam int D_C2      = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic probe = 1'b0;
    int   dir_id = 0;
    int   kcnt   = 0;
    int   total  = 0;
    int   bad    = 0;

    always #5 clk = ~clk;

    logic [AWA-1:0] rs1, rs2, rd, busy_rd;
    logic           we, busy_set;
    logic [XL-1:0]  wd;
    logic           a_ready, b_ready, a_b1, a_b2, b_b1, b_b2;
    logic [XL-1:0]  a_rd1, a_rd2, b_rd1, b_rd2;

    logic [AWC-1:0] c_rs1, c_rs2, c_rd, c_busy_rd;
    logic           c_we, c_busy_set, c_ready, c_b1, c_b2;
    logic [XC-1:0]  c_wd, c_rd1, c_rd2;

    regfile_sb u_a (
        .clk(clk), .rst_n(rst_n), .ready(a_ready),
        .rs1(rs1), .rs2(rs2), .rd1(a_rd1), .rd2(a_rd2),
        .rs1_busy(a_b1), .rs2_busy(a_b2),
        .we(we), .rd(rd), .wd(wd), .busy_set(busy_set), .busy_rd(busy_rd)
    );

    regfile_sb #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n), .ready(b_ready),
        .rs1(rs1), .rs2(rs2), .rd1(b_rd1), .rd2(b_rd2),
        .rs1_busy(b_b1), .rs2_busy(b_b2),
        .we(we), .rd(rd), .wd(wd), .busy_set(busy_set), .busy_rd(busy_rd)
    );

    regfile_sb #(.XLEN(XC), .NREGS(NRC), .ZERO_REG(0)) u_c (
        .clk(clk), .rst_n(rst_n), .ready(c_ready),
        .rs1(c_rs1), .rs2(c_rs2), .rd1(c_rd1), .rd2(c_rd2),
        .rs1_busy(c_b1), .rs2_busy(c_b2),
        .we(c_we), .rd(c_rd), .wd(c_wd), .busy_set(c_busy_set), .busy_rd(c_busy_rd)
    );

    // Reference model for A/B: edges since reset, register values, pending bits.
    int            m_edges = 0;
    logic [XL-1:0] m_regs [NR];
    bit            m_busy [NR];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_edges = 0;
            for (int i = 0; i < int'(NR); i++) m_busy[i] = 1'b0;
        end else if (m_edges < int'(NR)) begin
            m_regs[m_edges] = '0;
            m_edges++;
        end else begin
            if (we && rd != 0) begin
                m_regs[rd] = wd;
                m_busy[rd] = 1'b0;
            end
            if (busy_set && busy_rd != 0) m_busy[busy_rd] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Compare process: model checks every cycle plus literal expectations.
    always @(negedge clk or posedge probe) begin : cmp
        logic          run, wr;
        logic [XL-1:0] ea1, ea2, eb1, eb2;
        logic          eab1, eab2, ebb1, ebb2;
        logic [XC-1:0] ones;
        ones = '1;
        run  = (m_edges >= int'(NR));
        wr   = run && we && (rd != 0);
        ea1  = (!run || rs1 == 0) ? '0 : (wr && rd == rs1) ? wd : m_regs[rs1];
        ea2  = (!run || rs2 == 0) ? '0 : (wr && rd == rs2) ? wd : m_regs[rs2];
        eb1  = (!run || rs1 == 0) ? '0 : m_regs[rs1];
        eb2  = (!run || rs2 == 0) ? '0 : m_regs[rs2];
        eab1 = (!run || rs1 == 0 || (wr && rd == rs1)) ? 1'b0 : m_busy[rs1];
        eab2 = (!run || rs2 == 0 || (wr && rd == rs2)) ? 1'b0 : m_busy[rs2];
        ebb1 = (!run || rs1 == 0) ? 1'b0 : m_busy[rs1];
        ebb2 = (!run || rs2 == 0) ? 1'b0 : m_busy[rs2];
        chk("a_ready", 64'(a_ready), 64'(run));
        chk("b_ready", 64'(b_ready), 64'(run));
        chk("a_rd1", 64'(a_rd1), 64'(ea1));
        chk("a_rd2", 64'(a_rd2), 64'(ea2));
        chk("b_rd1", 64'(b_rd1), 64'(eb1));
        chk("b_rd2", 64'(b_rd2), 64'(eb2));
        chk("a_rs1_busy", 64'(a_b1), 64'(eab1));
        chk("a_rs2_busy", 64'(a_b2), 64'(eab2));
        chk("b_rs1_busy", 64'(b_b1), 64'(ebb1));
        chk("b_rs2_busy", 64'(b_b2), 64'(ebb2));
        case (dir_id)
            D_RSTCNT: begin
                chk("lit_a_ready_cnt", 64'(a_ready), 64'(kcnt >= 32));
                chk("lit_c_ready_cnt", 64'(c_ready), 64'(kcnt >= 16));
            end
            D_ZERO: begin
                chk("lit_zero_a_rd1", 64'(a_rd1), 64'h0);
                chk("lit_zero_a_rd2", 64'(a_rd2), 64'h0);
                chk("lit_zero_b_rd1", 64'(b_rd1), 64'h0);
            end
            D_BYP: begin
                chk("lit_byp_a_rd1", 64'(a_rd1), 64'hDEADBEEF);
                chk("lit_byp_b_rd1_old", 64'(b_rd1), 64'h0);
            end
            D_BYP2: begin
                chk("lit_byp2_a_rd1", 64'(a_rd1), 64'hDEADBEEF);
                chk("lit_byp2_b_rd1", 64'(b_rd1), 64'hDEADBEEF);
            end
            D_Z0: begin
                chk("lit_z0_a_rd1", 64'(a_rd1), 64'h0);
                chk("lit_z0_a_busy", 64'(a_b1), 64'h0);
                chk("lit_z0_b_rd1", 64'(b_rd1), 64'h0);
                chk("lit_z0_b_busy", 64'(b_b1), 64'h0);
            end
            D_SET7: begin
                chk("lit_set7_a_busy", 64'(a_b2), 64'h0);
                chk("lit_set7_b_busy", 64'(b_b2), 64'h0);
            end
            D_B7: begin
                chk("lit_b7_a_busy", 64'(a_b2), 64'h1);
                chk("lit_b7_b_busy", 64'(b_b2), 64'h1);
            end
            D_W7: begin
                chk("lit_w7_a_busy", 64'(a_b2), 64'h0);
                chk("lit_w7_b_busy", 64'(b_b2), 64'h1);
            end
            D_B7CLR: begin
                chk("lit_b7clr_a_busy", 64'(a_b2), 64'h0);
                chk("lit_b7clr_b_busy", 64'(b_b2), 64'h0);
            end
            D_WS7: begin
                chk("lit_ws7_a_busy", 64'(a_b2), 64'h0);
                chk("lit_ws7_a_rd2", 64'(a_rd2), 64'h88);
            end
            D_WS7B: begin
                chk("lit_ws7b_a_busy", 64'(a_b2), 64'h1);
                chk("lit_ws7b_b_busy", 64'(b_b2), 64'h1);
                chk("lit_ws7b_b_rd2", 64'(b_rd2), 64'h88);
            end
            D_B3: begin
                chk("lit_b3_a_busy", 64'(a_b1), 64'h1);
                chk("lit_b3_b_busy", 64'(b_b1), 64'h1);
            end
            D_RST: begin
                chk("lit_rst_a_ready", 64'(a_ready), 64'h0);
                chk("lit_rst_a_busy", 64'(a_b1), 64'h0);
                chk("lit_rst_b_busy", 64'(b_b1), 64'h0);
                chk("lit_rst_c_ready", 64'(c_ready), 64'h0);
            end
            D_C1: begin
                chk("lit_c1_rd1", 64'(c_rd1), ones);
            end
            D_C2: begin
                chk("lit_c2_rd1", 64'(c_rd1), ones);
                chk("lit_c2_rd2", 64'(c_rd2), ones);
                chk("lit_c2_busy", 64'(c_b1), 64'h0);
            end
            default: ;
        endcase
    end

    task automatic idle();
        we = 1'b0; rd = '0; wd = '0; busy_set = 1'b0; busy_rd = '0;
        rs1 = '0; rs2 = '0;
        c_we = 1'b0; c_rd = '0; c_wd = '0; c_busy_set = 1'b0; c_busy_rd = '0;
        c_rs1 = '0; c_rs2 = '0;
    endtask

    // Present the current inputs for one cycle: checked at the negedge,
    // consumed at the following posedge.
    task automatic step(input int id);
        dir_id = id;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_count();
        for (int k = 0; k <= 32; k++) begin
            kcnt = k;
            step(D_RSTCNT);
        end
    endtask

    task automatic zero_scan();
        for (int a = 0; a < int'(NR); a++) begin
            idle();
            rs1 = AWA'(a);
            rs2 = AWA'(int'(NR) - 1 - a);
            step(D_ZERO);
        end
    endtask

    initial begin
        idle();
        #1 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        reset_count();
        zero_scan();

        idle(); we = 1'b1; rd = 5'd5; wd = 32'hDEADBEEF; rs1 = 5'd5; step(D_BYP);
        idle(); rs1 = 5'd5; step(D_BYP2);
        idle(); we = 1'b1; rd = 5'd0; wd = 32'h1234; busy_set = 1'b1; busy_rd = 5'd0; step(D_Z0);
        idle(); step(D_Z0);
        idle(); busy_set = 1'b1; busy_rd = 5'd7; rs2 = 5'd7; step(D_SET7);
        idle(); rs2 = 5'd7; step(D_B7);
        idle(); we = 1'b1; rd = 5'd7; wd = 32'h77; rs2 = 5'd7; step(D_W7);
        idle(); rs2 = 5'd7; step(D_B7CLR);
        idle(); we = 1'b1; rd = 5'd7; wd = 32'h88; busy_set = 1'b1; busy_rd = 5'd7; rs2 = 5'd7;
        step(D_WS7);
        idle(); rs2 = 5'd7; step(D_WS7B);
        idle(); busy_set = 1'b1; busy_rd = 5'd3; step(D_NONE);
        idle(); rs1 = 5'd3; step(D_B3);

        rst_n = 1'b0;
        dir_id = D_RST;
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle();
        reset_count();
        zero_scan();

        idle(); c_we = 1'b1; c_rd = '0; c_wd = '1; c_rs1 = '0; step(D_C1);
        idle(); step(D_C2);

        for (int i = 0; i < 3000; i++) begin
            idle();
            we       = 1'($urandom_range(0, 1));
            rd       = ($urandom_range(0, 1) == 0) ? AWA'($urandom_range(0, 7)) : AWA'($urandom_range(0, NR - 1));
            wd       = $urandom;
            busy_set = ($urandom_range(0, 2) == 0);
            busy_rd  = ($urandom_range(0, 1) == 0) ? AWA'($urandom_range(0, 7)) : AWA'($urandom_range(0, NR - 1));
            rs1      = ($urandom_range(0, 3) == 0) ? rd : AWA'($urandom_range(0, 7));
            rs2      = ($urandom_range(0, 3) == 0) ? busy_rd : AWA'($urandom_range(0, NR - 1));
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                step(D_NONE);
                rst_n = 1'b1;
            end else begin
                step(D_NONE);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
